vga_scan_controller: RTL and testbench



---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_delay_line.sv | 34 +++
 rtl/vga_scan_controller.sv | 205 ++++++++++++++++++++
 tb/tb_vga_scan_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared helpers for the VGA scan controller: timing totals, sync polarity
// constant and BPC-to-DAC colour bit replication.
package vga_pkg;

  localparam bit SYNC_NEG = 1'b0;

  function automatic int unsigned h_total(input int unsigned active,
                                          input int unsigned front,
                                          input int unsigned sync_w,
                                          input int unsigned back);
    return active + front + sync_w + back;
  endfunction

  function automatic int unsigned v_total(input int unsigned active,
                                          input int unsigned front,
                                          input int unsigned sync_w,
                                          input int unsigned back);
    return active + front + sync_w + back;
  endfunction

  // Repeat the bpc-bit value MSB-first across dac_w bits; the last copy is cut short.
  function automatic logic [31:0] colour_expand(input logic [9:0]  value,
                                                input int unsigned bpc,
                                                input int unsigned dac_w);
    logic [31:0] res;
    res = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < dac_w) begin
        res[5'(dac_w - 1 - i)] = value[4'(bpc - 1 - (i % bpc))];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to align sync/blank/frame markers (and the
// colour-valid flag) with data returning from the video memory.
module vga_delay_line #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             vga_clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned PW = DEPTH * WIDTH;

  logic [PW-1:0] pipe_q;
  logic [PW-1:0] pipe_d;

  // Newest sample enters at the bottom, oldest leaves at the top.
  always_comb begin
    pipe_d = PW'({pipe_q, din});
  end

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      pipe_q <= {DEPTH{RESET_VAL}};
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign dout = pipe_q[PW-1 -: WIDTH];

endmodule

// File: rtl/vga_scan_controller.sv
// Parametrised VGA scan generator: timing counters, scaled linear framebuffer
// addressing and latency-matched sync/blank/colour outputs to the DAC.
module vga_scan_controller
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter bit          SYNC_ACTIVE = SYNC_NEG,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned BPC         = 4,
  parameter int unsigned DAC_W       = 10,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned CNT_W       = 11
) (
  input  logic                vga_clock,
  input  logic                resetn,
  input  logic [3*BPC-1:0]    pixel_colour,
  output logic [ADDR_W-1:0]   memory_address,
  output logic                mem_rd_en,
  output logic [DAC_W-1:0]    VGA_R,
  output logic [DAC_W-1:0]    VGA_G,
  output logic [DAC_W-1:0]    VGA_B,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                VGA_BLANK_N,
  output logic                VGA_SYNC,
  output logic                VGA_CLK,
  output logic                frame_start,
  output logic                vblank
);

  localparam int unsigned H_TOT = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOT = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned LAT   = MEM_LATENCY + 2;
  localparam int unsigned SUB_W = 3;

  localparam logic [CNT_W-1:0]  H_LAST     = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0]  V_LAST     = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0]  H_VIS      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]  V_VIS      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0]  H_VIS_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0]  HS_START   = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0]  HS_END     = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0]  VS_START   = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0]  VS_END     = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0]  DOT_MASK   = CNT_W'((1 << SCALE_SHIFT) - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST   = SUB_W'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);
  localparam logic [3:0]        SYNC_RST   = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0, 1'b0};

  logic [CNT_W-1:0]  h_q, h_d;
  logic [CNT_W-1:0]  v_q, v_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [SUB_W-1:0]  sub_y_q, sub_y_d;
  logic [ADDR_W-1:0] dot_q, dot_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_en_q, rd_en_d;
  logic              vblank_q, vblank_d;
  logic [DAC_W-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;

  logic       h_vis, v_vis, visible;
  logic       hs_raw, vs_raw, fs_raw;
  logic [3:0] sync_raw, sync_dly;
  logic       vis_dly;
  logic [BPC-1:0] pix_r, pix_g, pix_b;

  assign h_vis   = (h_q < H_VIS);
  assign v_vis   = (v_q < V_VIS);
  assign visible = h_vis && v_vis;

  // Counters, row/dot address walk and the stage-A fetch register.
  always_comb begin
    h_d        = h_q + CNT_W'(1);
    v_d        = v_q;
    row_base_d = row_base_q;
    sub_y_d    = sub_y_q;
    dot_d      = dot_q;
    addr_d     = addr_q;
    rd_en_d    = visible;

    if (visible) begin
      addr_d = dot_q;
    end
    if (h_vis && ((h_q & DOT_MASK) == DOT_MASK)) begin
      dot_d = dot_q + ADDR_W'(1);
    end
    if (v_vis && (h_q == H_VIS_LAST)) begin
      if (sub_y_q == SUB_LAST) begin
        sub_y_d    = '0;
        row_base_d = row_base_q + ROW_STRIDE;
      end else begin
        sub_y_d = sub_y_q + SUB_W'(1);
      end
    end

    // Line wrap reloads the dot pointer from the (possibly just advanced) row base.
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d        = '0;
        row_base_d = '0;
        sub_y_d    = '0;
      end else begin
        v_d = v_q + CNT_W'(1);
      end
      dot_d = row_base_d;
    end

    vblank_d = (v_d >= V_VIS);
  end

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      h_q        <= '0;
      v_q        <= '0;
      row_base_q <= '0;
      sub_y_q    <= '0;
      dot_q      <= '0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      vblank_q   <= 1'b0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      row_base_q <= row_base_d;
      sub_y_q    <= sub_y_d;
      dot_q      <= dot_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      vblank_q   <= vblank_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
    end
  end

  assign hs_raw   = (h_q >= HS_START) && (h_q < HS_END);
  assign vs_raw   = (v_q >= VS_START) && (v_q < VS_END);
  assign fs_raw   = (h_q == '0) && (v_q == '0);
  assign sync_raw = {hs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE,
                     vs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE,
                     visible, fs_raw};

  vga_delay_line #(
    .WIDTH    (4),
    .DEPTH    (LAT),
    .RESET_VAL(SYNC_RST)
  ) u_sync_dly (
    .vga_clock(vga_clock),
    .resetn   (resetn),
    .din      (sync_raw),
    .dout     (sync_dly)
  );

  // Visible flag aligned with the cycle in which memory data is valid.
  vga_delay_line #(
    .WIDTH    (1),
    .DEPTH    (MEM_LATENCY + 1),
    .RESET_VAL(1'b0)
  ) u_vis_dly (
    .vga_clock(vga_clock),
    .resetn   (resetn),
    .din      (visible),
    .dout     (vis_dly)
  );

  assign pix_r = pixel_colour[3*BPC-1 -: BPC];
  assign pix_g = pixel_colour[2*BPC-1 -: BPC];
  assign pix_b = pixel_colour[BPC-1:0];

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (vis_dly) begin
      r_d = DAC_W'(colour_expand(10'(pix_r), BPC, DAC_W));
      g_d = DAC_W'(colour_expand(10'(pix_g), BPC, DAC_W));
      b_d = DAC_W'(colour_expand(10'(pix_b), BPC, DAC_W));
    end
  end

  assign memory_address = addr_q;
  assign mem_rd_en      = rd_en_q;
  assign vblank         = vblank_q;
  assign VGA_R          = r_q;
  assign VGA_G          = g_q;
  assign VGA_B          = b_q;
  assign VGA_HS         = sync_dly[3];
  assign VGA_VS         = sync_dly[2];
  assign VGA_BLANK_N    = sync_dly[1];
  assign frame_start    = sync_dly[0];
  assign VGA_SYNC       = 1'b1;
  assign VGA_CLK        = vga_clock;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Scoreboard bench: a reference model pushes expected fetches and DAC outputs,
// a monitor pops and compares them; random memory contents and random resets.
module tb_vga_scan_controller;

  localparam int unsigned H_ACTIVE = 21, H_FRONT = 2, H_SYNC = 3, H_BACK = 2;
  localparam int unsigned V_ACTIVE = 11, V_FRONT = 1, V_SYNC = 2, V_BACK = 1;
  localparam bit          SYNC_ACTIVE = 1'b0;
  localparam int unsigned SCALE_SHIFT = 1, BPC = 3, DAC_W = 10, MEM_LATENCY = 3;
  localparam int unsigned ADDR_W = 17, CNT_W = 11;
  localparam int unsigned H_TOT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned FRAME = H_TOT * V_TOT;
  localparam int unsigned LAT   = MEM_LATENCY + 2;
  localparam int unsigned CW    = 3 * BPC;
  localparam int unsigned RPW   = MEM_LATENCY * CW;
  localparam int unsigned MEM_WORDS = 128;

  logic                vga_clock = 1'b0;
  logic                resetn;
  logic [CW-1:0]       pixel_colour;
  logic [ADDR_W-1:0]   memory_address;
  logic                mem_rd_en;
  logic [DAC_W-1:0]    VGA_R, VGA_G, VGA_B;
  logic                VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC, VGA_CLK;
  logic                frame_start, vblank;

  vga_scan_controller #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .SYNC_ACTIVE(SYNC_ACTIVE), .SCALE_SHIFT(SCALE_SHIFT), .BPC(BPC),
    .DAC_W(DAC_W), .MEM_LATENCY(MEM_LATENCY), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .vga_clock(vga_clock), .resetn(resetn), .pixel_colour(pixel_colour),
    .memory_address(memory_address), .mem_rd_en(mem_rd_en),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC(VGA_SYNC), .VGA_CLK(VGA_CLK),
    .frame_start(frame_start), .vblank(vblank)
  );

  always #5 vga_clock = ~vga_clock;

  // Video memory with MEM_LATENCY cycles of read latency.
  logic [CW-1:0]  mem_img [MEM_WORDS];
  logic [RPW-1:0] rd_pipe;
  always @(posedge vga_clock) rd_pipe <= RPW'({rd_pipe, mem_img[memory_address[6:0]]});
  assign pixel_colour = rd_pipe[RPW-1 -: CW];

  int unsigned rel_cyc;
  always @(posedge vga_clock or negedge resetn) begin
    if (!resetn) rel_cyc <= 0;
    else         rel_cyc <= rel_cyc + 1;
  end

  typedef struct { int unsigned tag; logic [ADDR_W-1:0] addr; } fetch_t;
  typedef struct { int unsigned tag; logic [3:0] ctl; logic [3*DAC_W-1:0] rgb; } dac_t;
  fetch_t fetch_q[$];
  dac_t   dac_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, rel_cyc, act, exp);
    end
  endtask

  task automatic fail_missing(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d: output present but no expected entry", name, rel_cyc);
  endtask

  // Concatenate enough copies of the value, then keep the top DAC_W bits.
  function automatic logic [DAC_W-1:0] expand(input logic [BPC-1:0] val);
    logic [63:0] acc;
    int unsigned reps;
    reps = (DAC_W + BPC - 1) / BPC;
    acc  = '0;
    for (int unsigned k = 0; k < reps; k++) acc = (acc << BPC) | 64'(val);
    return DAC_W'(acc >> (reps * BPC - DAC_W));
  endfunction

  // Reference model: what the counter position of this cycle implies downstream.
  always @(negedge vga_clock) begin : model_p
    int unsigned h, v, a;
    logic vis, hs, vs, fs;
    logic [CW-1:0] word;
    fetch_t f;
    dac_t d;
    if (resetn) begin
      h   = rel_cyc % H_TOT;
      v   = (rel_cyc / H_TOT) % V_TOT;
      vis = (h < H_ACTIVE) && (v < V_ACTIVE);
      a   = (v >> SCALE_SHIFT) * (H_ACTIVE >> SCALE_SHIFT) + (h >> SCALE_SHIFT);
      hs  = (h >= H_ACTIVE + H_FRONT && h < H_ACTIVE + H_FRONT + H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vs  = (v >= V_ACTIVE + V_FRONT && v < V_ACTIVE + V_FRONT + V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      fs  = (h == 0) && (v == 0);
      word = mem_img[7'(a)];
      if (vis) begin
        f.tag  = rel_cyc + 1;
        f.addr = ADDR_W'(a);
        fetch_q.push_back(f);
      end
      d.tag = rel_cyc + LAT;
      d.ctl = {hs, vs, vis, fs};
      d.rgb = vis ? {expand(word[CW-1 -: BPC]), expand(word[2*BPC-1 -: BPC]), expand(word[BPC-1:0])} : '0;
      dac_q.push_back(d);
    end
  end

  logic [ADDR_W-1:0] last_addr;
  bit                have_frame;
  int unsigned       frm_cycles, frm_blank;

  always @(negedge vga_clock) begin : monitor_p
    fetch_t f;
    dac_t d;
    chk("vga_sync", 64'(VGA_SYNC), 64'(1));
    chk("vga_clk", 64'(VGA_CLK), 64'(vga_clock));
    if (!resetn) begin
      fetch_q.delete();
      dac_q.delete();
      last_addr  = '0;
      have_frame = 0;
      chk("reset_ctl", 64'({VGA_HS, VGA_VS, VGA_BLANK_N, frame_start, mem_rd_en, vblank}),
          64'({~SYNC_ACTIVE, ~SYNC_ACTIVE, 4'b0000}));
      chk("reset_addr", 64'(memory_address), 64'(0));
      chk("reset_rgb", 64'({VGA_R, VGA_G, VGA_B}), 64'(0));
    end else begin
      chk("vblank", 64'(vblank), 64'(((rel_cyc / H_TOT) % V_TOT) >= V_ACTIVE));

      if (mem_rd_en) begin
        if (fetch_q.size() == 0) fail_missing("fetch_unexpected");
        else begin
          f = fetch_q.pop_front();
          chk("fetch_cycle", 64'(rel_cyc), 64'(f.tag));
          chk("fetch_addr", 64'(memory_address), 64'(f.addr));
          last_addr = f.addr;
        end
      end else begin
        if (fetch_q.size() > 0 && fetch_q[0].tag == rel_cyc) begin
          f = fetch_q.pop_front();
          chk("fetch_rd_en", 64'(mem_rd_en), 64'(1));
        end
        chk("addr_hold", 64'(memory_address), 64'(last_addr));
      end

      if (rel_cyc < LAT) begin
        chk("fill_ctl", 64'({VGA_HS, VGA_VS, VGA_BLANK_N, frame_start}),
            64'({~SYNC_ACTIVE, ~SYNC_ACTIVE, 2'b00}));
        chk("fill_rgb", 64'({VGA_R, VGA_G, VGA_B}), 64'(0));
      end else if (dac_q.size() == 0) begin
        fail_missing("dac_unexpected");
      end else begin
        d = dac_q.pop_front();
        chk("dac_cycle", 64'(rel_cyc), 64'(d.tag));
        chk("dac_ctl", 64'({VGA_HS, VGA_VS, VGA_BLANK_N, frame_start}), 64'(d.ctl));
        chk("dac_rgb", 64'({VGA_R, VGA_G, VGA_B}), 64'(d.rgb));
        if (frame_start) begin
          if (have_frame) begin
            chk("frame_len", 64'(frm_cycles), 64'(FRAME));
            chk("frame_visible", 64'(frm_blank), 64'(H_ACTIVE * V_ACTIVE));
          end
          chk("frame_phase", 64'((rel_cyc - LAT) % FRAME), 64'(0));
          chk("fs_colour", 64'({VGA_R, VGA_G, VGA_B}),
              64'({10'b1011011011, 10'b0100100100, 10'b1111111111}));
          have_frame = 1;
          frm_cycles = 0;
          frm_blank  = 0;
        end
        frm_cycles++;
        if (VGA_BLANK_N) frm_blank++;
      end
    end
  end

  task automatic pulse_reset();
    #1 resetn = 1'b0;
    repeat ($urandom_range(1, 3)) @(posedge vga_clock);
    #1 resetn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem_img[i] = CW'($urandom);
    mem_img[0] = 9'b101_010_111;
    resetn = 1'b0;
    repeat (4) @(posedge vga_clock);
    #1 resetn = 1'b1;
    // First reset lands on a visible line in the middle of the second frame.
    repeat (FRAME + 5 * H_TOT + $urandom_range(0, H_ACTIVE - 1)) @(posedge vga_clock);
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(FRAME, 3 * FRAME)) @(posedge vga_clock);
      pulse_reset();
    end
    repeat (2 * FRAME + 10) @(posedge vga_clock);
    @(negedge vga_clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
